// File: rtl/branch_target_predictor_if.sv
// Fetch/execute-side signal bundle for the branch target predictor.
// The master side is the core (lookup and update driver); the slave side is the predictor.
interface branch_target_predictor_if #(
    parameter int N = 32
);
    logic [N-1:0]  lookup_pc;
    logic          pred_hit;
    logic          pred_taken;
    logic [N-1:0]  pred_target;
    logic          upd_valid;
    logic [N-1:0]  upd_pc;
    logic          upd_taken;
    logic [N-1:0]  upd_target;
    logic          upd_mispredict;
    logic          flush;
    logic [31:0]   stat_branches;
    logic [31:0]   stat_mispredicts;

    modport master (
        output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush,
        input  pred_hit, pred_taken, pred_target, stat_branches, stat_mispredicts
    );

    modport slave (
        input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict, flush,
        output pred_hit, pred_taken, pred_target, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped saturating-counter direction predictor with a tagged BTB.
// Lookup is combinational from table state; resolved branches update one per cycle.
module branch_target_predictor #(
    parameter int N  = 32,
    parameter int M  = 16,
    parameter int CW = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    branch_target_predictor_if.slave   bus
);
    localparam int IW = $clog2(M);
    localparam int TW = N - 2 - IW;
    localparam logic [CW-1:0] CTR_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CTR_WEAK = CW'(1 << (CW - 1));

    logic            valid_q  [M];
    logic            valid_d  [M];
    logic [TW-1:0]   tag_q    [M];
    logic [TW-1:0]   tag_d    [M];
    logic [N-1:0]    target_q [M];
    logic [N-1:0]    target_d [M];
    logic [CW-1:0]   ctr_q    [M];
    logic [CW-1:0]   ctr_d    [M];
    logic [31:0]     stat_branches_q, stat_branches_d;
    logic [31:0]     stat_mispredicts_q, stat_mispredicts_d;

    logic [IW-1:0]   lk_idx, up_idx;
    logic [TW-1:0]   lk_tag, up_tag;
    logic            lk_hit, up_hit;

    // Instruction alignment bits never participate in indexing or tagging.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};

    assign lk_idx = bus.lookup_pc[IW+1:2];
    assign lk_tag = bus.lookup_pc[N-1:IW+2];
    assign up_idx = bus.upd_pc[IW+1:2];
    assign up_tag = bus.upd_pc[N-1:IW+2];

    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    assign bus.pred_hit         = lk_hit;
    assign bus.pred_taken       = lk_hit & ctr_q[lk_idx][CW-1];
    assign bus.pred_target      = lk_hit ? target_q[lk_idx] : '0;
    assign bus.stat_branches    = stat_branches_q;
    assign bus.stat_mispredicts = stat_mispredicts_q;

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (bus.flush) begin
            for (int i = 0; i < M; i++) begin
                valid_d[i] = 1'b0;
                ctr_d[i]   = CTR_MAX;
            end
        end else if (bus.upd_valid) begin
            if (up_hit) begin
                if (bus.upd_taken) begin
                    target_d[up_idx] = bus.upd_target;
                    if (ctr_q[up_idx] != CTR_MAX)
                        ctr_d[up_idx] = ctr_q[up_idx] + CW'(1);
                end else if (ctr_q[up_idx] != '0) begin
                    ctr_d[up_idx] = ctr_q[up_idx] - CW'(1);
                end
            end else if (bus.upd_taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = bus.upd_target;
                ctr_d[up_idx]    = CTR_WEAK;
            end
        end
    end

    // Statistics ignore flush and stick at all-ones instead of wrapping.
    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (bus.upd_valid && (stat_branches_q != 32'hFFFF_FFFF))
            stat_branches_d = stat_branches_q + 32'd1;
        if (bus.upd_valid && bus.upd_mispredict && (stat_mispredicts_q != 32'hFFFF_FFFF))
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < M; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_MAX;
            end
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            valid_q            <= valid_d;
            tag_q              <= tag_d;
            target_q           <= target_d;
            ctr_q              <= ctr_d;
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end
endmodule

// File: tb/tb_branch_target_predictor.sv
// Randomized plus directed bench for branch_target_predictor against a behavioural table model.
module tb_branch_target_predictor;
    localparam int N  = 32;
    localparam int M  = 16;
    localparam int CW = 2;
    localparam int IW = $clog2(M);
    localparam int CMAX = (1 << CW) - 1;

    logic clk;
    logic rst;

    branch_target_predictor_if #(.N(N)) bus ();

    branch_target_predictor #(.N(N), .M(M), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: one record per table slot, plain integer arithmetic.
    bit          m_valid  [M];
    longint      m_tag    [M];
    logic [31:0] m_target [M];
    int          m_ctr    [M];
    longint      m_br;
    longint      m_mp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int slot_of(input logic [31:0] pc);
        return int'((pc >> 2) % M);
    endfunction

    function automatic longint tag_of(input logic [31:0] pc);
        return longint'(pc >> (IW + 2));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < M; i++) begin
            m_valid[i]  = 0;
            m_tag[i]    = 0;
            m_target[i] = '0;
            m_ctr[i]    = CMAX;
        end
        m_br = 0;
        m_mp = 0;
    endtask

    task automatic model_update(input bit uv, input logic [31:0] upc, input bit ut,
                                input logic [31:0] utg, input bit um, input bit fl);
        int s;
        s = slot_of(upc);
        if (uv) begin
            if (m_br < 64'hFFFF_FFFF) m_br++;
            if (um && m_mp < 64'hFFFF_FFFF) m_mp++;
        end
        if (fl) begin
            for (int i = 0; i < M; i++) begin
                m_valid[i] = 0;
                m_ctr[i]   = CMAX;
            end
        end else if (uv) begin
            if (m_valid[s] && m_tag[s] == tag_of(upc)) begin
                if (ut) begin
                    m_ctr[s]    = (m_ctr[s] + 1 > CMAX) ? CMAX : m_ctr[s] + 1;
                    m_target[s] = utg;
                end else begin
                    m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
                end
            end else if (ut) begin
                m_valid[s]  = 1;
                m_tag[s]    = tag_of(upc);
                m_target[s] = utg;
                m_ctr[s]    = 1 << (CW - 1);
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        int  s;
        bit  e_hit;
        s     = slot_of(bus.lookup_pc);
        e_hit = m_valid[s] && (m_tag[s] == tag_of(bus.lookup_pc));
        check({tag, ".hit"},    64'(bus.pred_hit),    64'(e_hit));
        check({tag, ".taken"},  64'(bus.pred_taken),  64'(e_hit && (m_ctr[s] >= (1 << (CW - 1)))));
        check({tag, ".target"}, 64'(bus.pred_target), e_hit ? 64'(m_target[s]) : 64'd0);
        check({tag, ".stat_br"}, 64'(bus.stat_branches),    64'(m_br));
        check({tag, ".stat_mp"}, 64'(bus.stat_mispredicts), 64'(m_mp));
    endtask

    // Called at a negedge: drive, check pre-update lookup, clock, advance model.
    task automatic step(input string tag, input logic [31:0] lpc, input bit uv,
                        input logic [31:0] upc, input bit ut, input logic [31:0] utg,
                        input bit um, input bit fl);
        bus.lookup_pc      = lpc;
        bus.upd_valid      = uv;
        bus.upd_pc         = upc;
        bus.upd_taken      = ut;
        bus.upd_target     = utg;
        bus.upd_mispredict = um;
        bus.flush          = fl;
        #1;
        check_outputs(tag);
        @(posedge clk);
        model_update(uv, upc, ut, utg, um, fl);
        @(negedge clk);
    endtask

    task automatic look(input string tag, input logic [31:0] lpc);
        step(tag, lpc, 0, 32'h0, 0, 32'h0, 0, 0);
    endtask

    task automatic upd(input string tag, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utg, input bit um);
        step(tag, upc, 1, upc, ut, utg, um, 0);
    endtask

    task automatic do_reset(input string tag, input logic [31:0] lpc);
        bus.lookup_pc      = lpc;
        bus.upd_valid      = 1;
        bus.upd_pc         = lpc;
        bus.upd_taken      = 1;
        bus.upd_target     = 32'hDEAD_0000;
        bus.upd_mispredict = 1;
        bus.flush          = 0;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] rpc, rlk;

    initial begin
        bus.lookup_pc = '0; bus.upd_valid = 0; bus.upd_pc = '0; bus.upd_taken = 0;
        bus.upd_target = '0; bus.upd_mispredict = 0; bus.flush = 0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        look("reset_0x40", 32'h40);
        upd("alloc_0x40", 32'h40, 1, 32'h100, 0);
        look("hit_0x40", 32'h40);
        look("miss_0x44", 32'h44);
        for (int i = 0; i < 4; i++) upd("sat_up", 32'h40, 1, 32'h100, 0);
        look("ctr_max", 32'h40);
        for (int i = 0; i < 2; i++) upd("dn", 32'h40, 0, 32'h0, 1);
        look("ctr_1", 32'h40);
        for (int i = 0; i < 3; i++) upd("sat_dn", 32'h40, 0, 32'h0, 0);
        look("ctr_0", 32'h40);
        upd("up_from_0", 32'h40, 1, 32'h140, 0);
        look("ctr_1_newtgt", 32'h40);

        upd("alias_0x80", 32'h80, 1, 32'h200, 1);
        look("alias_old", 32'h40);
        look("alias_new", 32'h80);
        upd("miss_nt_0x40", 32'h40, 0, 32'h0, 0);
        look("alias_intact", 32'h80);

        step("same_cycle", 32'h40, 1, 32'h40, 1, 32'h300, 0, 0);
        look("same_cycle_next", 32'h40);

        step("flush_upd", 32'h80, 1, 32'h80, 1, 32'h400, 0, 1);
        look("flush_0x80", 32'h80);
        look("flush_0x40", 32'h40);

        do_reset("reset_mid", 32'h40);
        for (int i = 0; i < 10; i++)
            upd("ten_upd", 32'h1000 + 32'(i * 4), (i % 2) == 0, 32'h2000 + 32'(i), (i % 4) == 1 || i == 9);
        look("ten_stats", 32'h1000);
        check("ten_br_abs", 64'(bus.stat_branches), 64'd10);
        check("ten_mp_abs", 64'(bus.stat_mispredicts), 64'd3);

        force dut.stat_branches_q = 32'hFFFF_FFFE;
        force dut.stat_mispredicts_q = 32'hFFFF_FFFF;
        #1;
        release dut.stat_branches_q;
        release dut.stat_mispredicts_q;
        m_br = 64'hFFFF_FFFE;
        m_mp = 64'hFFFF_FFFF;
        @(negedge clk);
        upd("sat_a", 32'h40, 1, 32'h500, 1);
        upd("sat_b", 32'h40, 1, 32'h500, 1);
        look("sat_hold", 32'h40);

        do_reset("reset_rand", 32'h40);
        for (int i = 0; i < 500; i++) begin
            rpc = (32'($urandom_range(0, 3)) << (IW + 2)) | (32'($urandom_range(0, M - 1)) << 2)
                  | 32'($urandom_range(0, 3));
            rlk = ($urandom_range(0, 1) == 1) ? rpc
                  : ((32'($urandom_range(0, 3)) << (IW + 2)) | (32'($urandom_range(0, M - 1)) << 2));
            step("rand", rlk, $urandom_range(0, 3) != 0, rpc, $urandom_range(0, 2) != 0,
                 $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0);
            if (i == 250) do_reset("reset_rand_mid", rpc);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
